// File: rtl/reg_file.sv
// Integer register file for the single-cycle RV32 core.
// Holds x1..x31 in flops; x0 has no storage and always reads as zero.
// Two combinational read ports feed the ALU operand muxes, and one
// clocked write port takes the writeback result. There is no
// write-to-read bypass: a read in the same cycle as a write to the same
// register returns the old value until the edge.

module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic            reg_write
);

    // Physical storage for x1..x(NREGS-1); index 0 deliberately absent.
    logic [XLEN-1:0] regs [1:NREGS-1];

    // Write port: async clear of every register, else one write per edge, x0 writes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (rd != '0)) begin
            regs[rd] <= wd;
        end
    end

    // Read port 1: address decode over x1..x31 so that x0 falls through to zero.
    always_comb begin
        rd1 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1 == AW'(i)) begin
                rd1 = regs[i];
            end
        end
    end

    // Read port 2: identical and independent of port 1, so rs1 == rs2 is harmless.
    always_comb begin
        rd2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs2 == AW'(i)) begin
                rd2 = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written
// reset sequences and randomized traffic against a plain array model.

module tb_reg_file;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        reg_write;

    int errors;
    int checks;

    // Architectural view: 32 registers, x0 forced to zero on every read.
    logic [31:0] model [32];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        we;
        logic [31:0] eb1;
        logic [31:0] eb2;
        logic [31:0] ea1;
        logic [31:0] ea2;
    } vec_t;

    vec_t table_v [9];

    reg_file #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd1       (rd1),
        .rd2       (rd2),
        .rd        (rd),
        .wd        (wd),
        .reg_write (reg_write)
    );

    // Gated clock so the reset test can run with the clock stopped.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    // Builds a vector with expectations from the model, then commits the write to the model.
    function automatic vec_t make_vec(input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] wa, input logic [31:0] data,
                                      input logic en);
        vec_t v;
        v.rs1 = a1;
        v.rs2 = a2;
        v.rd  = wa;
        v.wd  = data;
        v.we  = en;
        v.eb1 = model_read(a1);
        v.eb2 = model_read(a2);
        if (en && wa != 5'd0) model[wa] = data;
        v.ea1 = model_read(a1);
        v.ea2 = model_read(a2);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one vector between edges, checks reads before and after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        rs1       = v.rs1;
        rs2       = v.rs2;
        rd        = v.rd;
        wd        = v.wd;
        reg_write = v.we;
        #1;
        checkOutput({tag, " rd1 pre"}, rd1, v.eb1);
        checkOutput({tag, " rd2 pre"}, rd2, v.eb2);
        @(posedge clk);
        #1;
        checkOutput({tag, " rd1 post"}, rd1, v.ea1);
        checkOutput({tag, " rd2 post"}, rd2, v.ea2);
        reg_write = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [4:0] probe [3];

        errors    = 0;
        checks    = 0;
        clk_run   = 1'b0;
        rst_n     = 1'b1;
        rs1       = 5'd0;
        rs2       = 5'd0;
        rd        = 5'd0;
        wd        = 32'h0;
        reg_write = 1'b0;
        model_clear();

        // Reset with the clock stopped.
        probe[0] = 5'd1;
        probe[1] = 5'd5;
        probe[2] = 5'd31;
        #3;
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            rs1 = probe[i];
            rs2 = probe[i];
            #1;
            checkOutput($sformatf("reset low x%0d rd1", probe[i]), rd1, 32'h0);
            checkOutput($sformatf("reset low x%0d rd2", probe[i]), rd2, 32'h0);
        end
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            rs1 = probe[i];
            rs2 = probe[i];
            #1;
            checkOutput($sformatf("reset done x%0d rd1", probe[i]), rd1, 32'h0);
            checkOutput($sformatf("reset done x%0d rd2", probe[i]), rd2, 32'h0);
        end

        clk_run = 1'b1;

        // Directed table: rs1, rs2, rd, wd, we, pre rd1/rd2, post rd1/rd2.
        table_v[0] = '{5'd5,  5'd0,  5'd5,  32'd42,        1'b1, 32'd0,         32'd0,  32'd42,        32'd0};
        table_v[1] = '{5'd0,  5'd5,  5'd0,  32'hDEADBEEF,  1'b1, 32'd0,         32'd42, 32'd0,         32'd42};
        table_v[2] = '{5'd7,  5'd7,  5'd7,  32'd100,       1'b1, 32'd0,         32'd0,  32'd100,       32'd100};
        table_v[3] = '{5'd7,  5'd5,  5'd7,  32'd555,       1'b0, 32'd100,       32'd42, 32'd100,       32'd42};
        table_v[4] = '{5'd7,  5'd5,  5'd7,  32'd555,       1'b0, 32'd100,       32'd42, 32'd100,       32'd42};
        table_v[5] = '{5'd9,  5'd9,  5'd9,  32'd1,         1'b1, 32'd0,         32'd0,  32'd1,         32'd1};
        table_v[6] = '{5'd9,  5'd9,  5'd9,  32'd2,         1'b1, 32'd1,         32'd1,  32'd2,         32'd2};
        table_v[7] = '{5'd31, 5'd1,  5'd31, 32'hFFFFFFFF,  1'b1, 32'd0,         32'd0,  32'hFFFFFFFF,  32'd0};
        table_v[8] = '{5'd31, 5'd1,  5'd1,  32'h12345678,  1'b1, 32'hFFFFFFFF,  32'd0,  32'hFFFFFFFF,  32'h12345678};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(table_v[i], $sformatf("table[%0d]", i));
            if (table_v[i].we && table_v[i].rd != 5'd0) model[table_v[i].rd] = table_v[i].wd;
        end

        // Fill x1..x31 with their own index.
        for (int i = 1; i < 32; i++) begin
            v = make_vec(5'(i), 5'(i - 1), 5'(i), 32'(i), 1'b1);
            applyStimulus(v, $sformatf("fill x%0d", i));
        end

        // Reset asserted between edges with a write pending to x3.
        @(negedge clk);
        rs1       = 5'd3;
        rs2       = 5'd3;
        rd        = 5'd3;
        wd        = 32'd77;
        reg_write = 1'b1;
        #1;
        checkOutput("midreset x3 before", rd1, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset immediate rd1", rd1, 32'h0);
        checkOutput("midreset immediate rd2", rd2, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            checkOutput($sformatf("midreset rd1 x%0d", i), rd1, 32'h0);
            checkOutput($sformatf("midreset rd2 x%0d", 31 - i), rd2, 32'h0);
        end
        @(negedge clk);
        reg_write = 1'b0;
        rst_n     = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rs1 = 5'd3;
        rs2 = 5'd1;
        #1;
        checkOutput("after release x3", rd1, 32'h0);
        checkOutput("after release x1", rd2, 32'h0);

        // First write after release must land.
        v = make_vec(5'd3, 5'd0, 5'd3, 32'd77, 1'b1);
        applyStimulus(v, "post-release write");

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            v = make_vec(5'($urandom_range(31)), 5'($urandom_range(31)),
                         5'($urandom_range(31)), $urandom,
                         ($urandom_range(3) != 0));
            applyStimulus(v, $sformatf("rand[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
